// File: rtl/ldpc_bf_decoder.sv
// Hard-decision bit-flipping LDPC decoder: one parity row per cycle, at most one flip per iteration.
// Latency: (flips+1)*(M+1) cycles from accept to out_valid; M = N-K.
// Backpressure: in_ready only in IDLE, result held in DONE until out_ready; optional iter_count port via LDPC_BF_ITER_COUNT_EN.
module ldpc_bf_decoder #(
  parameter int N        = 11,
  parameter int K        = 6,
  parameter int MAX_ITER = 8,
  parameter logic [(N-K)*N-1:0] H_MATRIX = {11'h418, 11'h20C, 11'h126, 11'h083, 11'h071}
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] code_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] decoded,
  output logic [K-1:0] info_out,
  output logic         success
`ifdef LDPC_BF_ITER_COUNT_EN
  ,
  output logic [7:0]   iter_count
`endif
);

  localparam int M  = N - K;
  localparam int CW = $clog2(M + 1);
  localparam int RW = (M > 1) ? $clog2(M) : 1;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SYND,
    S_EVAL,
    S_DONE
  } state_t;

  state_t          state_q;
  logic [N-1:0]    word_q;
  logic [M-1:0]    syn_q;
  logic [RW-1:0]   row_q;
  logic [7:0]      iter_q;
  logic [CW-1:0]   cnt_q [N];
  logic            in_ready_q;
  logic            out_valid_q;
  logic [N-1:0]    decoded_q;
  logic            success_q;

  logic [N-1:0]    row_bits;
  logic            row_odd;
  logic [IW-1:0]   flip_idx;
  logic [CW-1:0]   best_cnt;
  logic [N-1:0]    flip_mask;

  // Current parity row and whether the word violates it.
  always_comb begin
    row_bits = H_MATRIX[int'(row_q)*N +: N];
    row_odd  = ^(word_q & row_bits);
  end

  // Pick the bit with the most unsatisfied checks; >= makes the highest index win ties.
  always_comb begin
    flip_idx = '0;
    best_cnt = cnt_q[0];
    for (int j = 1; j < N; j++) begin
      if (cnt_q[j] >= best_cnt) begin
        best_cnt = cnt_q[j];
        flip_idx = IW'(j);
      end
    end
    flip_mask = N'(1) << flip_idx;
  end

  // Control FSM with all datapath state and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      word_q      <= '0;
      syn_q       <= '0;
      row_q       <= '0;
      iter_q      <= '0;
      for (int j = 0; j < N; j++) cnt_q[j] <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      decoded_q   <= '0;
      success_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          // in_ready is always high here, so in_valid alone completes the handshake.
          if (in_valid) begin
            word_q     <= code_in;
            iter_q     <= '0;
            syn_q      <= '0;
            row_q      <= '0;
            for (int j = 0; j < N; j++) cnt_q[j] <= '0;
            in_ready_q <= 1'b0;
            state_q    <= S_SYND;
          end
        end
        S_SYND: begin
          if (row_odd) begin
            syn_q[row_q] <= 1'b1;
            for (int j = 0; j < N; j++) begin
              if (row_bits[j]) cnt_q[j] <= cnt_q[j] + CW'(1);
            end
          end
          if (row_q == RW'(M - 1)) begin
            row_q   <= '0;
            state_q <= S_EVAL;
          end else begin
            row_q <= row_q + RW'(1);
          end
        end
        S_EVAL: begin
          if (syn_q == '0) begin
            decoded_q   <= word_q;
            success_q   <= 1'b1;
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end else if (iter_q == 8'(MAX_ITER)) begin
            decoded_q   <= word_q;
            success_q   <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end else begin
            word_q  <= word_q ^ flip_mask;
            iter_q  <= iter_q + 8'd1;
            syn_q   <= '0;
            for (int j = 0; j < N; j++) cnt_q[j] <= '0;
            state_q <= S_SYND;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign decoded   = decoded_q;
  assign info_out  = decoded_q[K-1:0];
  assign success   = success_q;

`ifdef LDPC_BF_ITER_COUNT_EN
  logic [7:0] iter_count_q;

  // Flip count captured alongside the result so it stays stable in DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iter_count_q <= '0;
    end else if (state_q == S_EVAL && (syn_q == '0 || iter_q == 8'(MAX_ITER))) begin
      iter_count_q <= iter_q;
    end
  end

  assign iter_count = iter_count_q;
`endif

endmodule

// File: tb/tb_ldpc_bf_decoder.sv
// Bench for ldpc_bf_decoder: three instances (MAX_ITER 8, 1, 0) checked against a behavioural model.
// Latency is measured in clock edges after the accepting edge.
// Output backpressure is exercised by holding out_ready low.
module tb_ldpc_bf_decoder;
  localparam int N = 11;
  localparam int K = 6;
  localparam int M = 5;
  localparam logic [54:0] H_TB = {11'h418, 11'h20C, 11'h126, 11'h083, 11'h071};

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  in_valid_s = '0;
  logic [2:0]  out_ready_s = '0;
  logic [10:0] code_in_s [3];
  wire  [2:0]  in_ready_s;
  wire  [2:0]  out_valid_s;
  wire  [2:0]  success_s;
  wire  [10:0] decoded_s [3];
  wire  [5:0]  info_s [3];
`ifdef LDPC_BF_ITER_COUNT_EN
  wire  [7:0]  iter_s [3];
`endif

  int checks = 0;
  int errors = 0;
  int mx [3] = '{8, 1, 0};

  always #5 clk = ~clk;

  ldpc_bf_decoder #(.MAX_ITER(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid_s[0]), .in_ready(in_ready_s[0]),
    .code_in(code_in_s[0]), .out_valid(out_valid_s[0]), .out_ready(out_ready_s[0]),
    .decoded(decoded_s[0]), .info_out(info_s[0]), .success(success_s[0])
`ifdef LDPC_BF_ITER_COUNT_EN
    , .iter_count(iter_s[0])
`endif
  );

  ldpc_bf_decoder #(.MAX_ITER(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid_s[1]), .in_ready(in_ready_s[1]),
    .code_in(code_in_s[1]), .out_valid(out_valid_s[1]), .out_ready(out_ready_s[1]),
    .decoded(decoded_s[1]), .info_out(info_s[1]), .success(success_s[1])
`ifdef LDPC_BF_ITER_COUNT_EN
    , .iter_count(iter_s[1])
`endif
  );

  ldpc_bf_decoder #(.MAX_ITER(0)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid_s[2]), .in_ready(in_ready_s[2]),
    .code_in(code_in_s[2]), .out_valid(out_valid_s[2]), .out_ready(out_ready_s[2]),
    .decoded(decoded_s[2]), .info_out(info_s[2]), .success(success_s[2])
`ifdef LDPC_BF_ITER_COUNT_EN
    , .iter_count(iter_s[2])
`endif
  );

  // Reference: repeat { evaluate all checks; stop if clean or out of budget; flip the most-blamed bit }.
  function automatic void model_decode(input logic [10:0] w, input int maxit,
                                       output logic [10:0] dec, output bit ok, output int its);
    logic [54:0] h;
    logic [10:0] x;
    logic [10:0] row;
    int cnt [11];
    int unsat;
    int best;
    h = H_TB;
    x = w;
    its = 0;
    ok = 1'b0;
    for (int guard = 0; guard < 300; guard++) begin
      unsat = 0;
      for (int j = 0; j < N; j++) cnt[j] = 0;
      for (int r = 0; r < M; r++) begin
        row = h[r*N +: N];
        if (($countones(x & row) % 2) == 1) begin
          unsat++;
          for (int j = 0; j < N; j++) if (row[j]) cnt[j]++;
        end
      end
      if (unsat == 0) begin
        ok = 1'b1;
        break;
      end
      if (its == maxit) begin
        ok = 1'b0;
        break;
      end
      best = 0;
      for (int j = 0; j < N; j++) if (cnt[j] >= cnt[best]) best = j;
      x[best] = ~x[best];
      its++;
    end
    dec = x;
  endfunction

  // Offer a word to instance sel and wait for its result; returns at a falling edge with out_valid high.
  task automatic do_decode(input int sel, input logic [10:0] w, output int lat, output bit to);
    int g;
    to = 1'b0;
    lat = 0;
    g = 0;
    code_in_s[sel] = w;
    in_valid_s[sel] = 1'b1;
    while (in_ready_s[sel] !== 1'b1) begin
      if (g >= 20) begin
        to = 1'b1;
        in_valid_s[sel] = 1'b0;
        return;
      end
      @(negedge clk);
      g++;
    end
    @(posedge clk);
    @(negedge clk);
    in_valid_s[sel] = 1'b0;
    while (out_valid_s[sel] !== 1'b1) begin
      if (lat >= 400) begin
        to = 1'b1;
        return;
      end
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic release_out(input int sel);
    out_ready_s[sel] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready_s[sel] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #2 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      checks++;
      if (in_ready_s[s] !== 1'b1 || out_valid_s[s] !== 1'b0) begin
        errors++;
        $display("FAIL reset_handshake inst%0d: in_ready=%b out_valid=%b, want 1/0", s, in_ready_s[s], out_valid_s[s]);
      end
      checks++;
      if (decoded_s[s] !== 11'h000 || info_s[s] !== 6'h00 || success_s[s] !== 1'b0) begin
        errors++;
        $display("FAIL reset_outputs inst%0d: decoded=%h info=%h success=%b, want 000/00/0", s, decoded_s[s], info_s[s], success_s[s]);
      end
`ifdef LDPC_BF_ITER_COUNT_EN
      checks++;
      if (iter_s[s] !== 8'd0) begin
        errors++;
        $display("FAIL reset_iter inst%0d: got %0d want 0", s, iter_s[s]);
      end
`endif
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [10:0] win  [5];
    logic [10:0] wdec [5];
    int          wit  [5];
    int lat;
    bit to;
    win  = '{11'h000, 11'h0C1, 11'h0C0, 11'h2C1, 11'h201};
    wdec = '{11'h000, 11'h0C1, 11'h0C1, 11'h0C1, 11'h000};
    wit  = '{0, 0, 1, 1, 2};
    for (int i = 0; i < 5; i++) begin
      do_decode(0, win[i], lat, to);
      checks++;
      if (to) begin
        errors++;
        $display("FAIL directed_timeout word=%h: no out_valid", win[i]);
        continue;
      end
      checks++;
      if (decoded_s[0] !== wdec[i] || info_s[0] !== wdec[i][5:0]) begin
        errors++;
        $display("FAIL directed_decoded word=%h: got %h/%h want %h/%h", win[i], decoded_s[0], info_s[0], wdec[i], wdec[i][5:0]);
      end
      checks++;
      if (success_s[0] !== 1'b1) begin
        errors++;
        $display("FAIL directed_success word=%h: got %b want 1", win[i], success_s[0]);
      end
      checks++;
      if (lat != (wit[i] + 1) * (M + 1)) begin
        errors++;
        $display("FAIL directed_latency word=%h: got %0d edges want %0d", win[i], lat, (wit[i] + 1) * (M + 1));
      end
`ifdef LDPC_BF_ITER_COUNT_EN
      checks++;
      if (iter_s[0] !== 8'(wit[i])) begin
        errors++;
        $display("FAIL directed_iter word=%h: got %0d want %0d", win[i], iter_s[0], wit[i]);
      end
`endif
      release_out(0);
    end
  endtask

  task automatic test_max_iter();
    int lat;
    bit to;
    // Budget of one flip: 0x201 needs two flips, so it ends unresolved after flipping bit 0.
    do_decode(1, 11'h201, lat, to);
    checks++;
    if (to || decoded_s[1] !== 11'h200 || success_s[1] !== 1'b0 || lat != 2 * (M + 1)) begin
      errors++;
      $display("FAIL budget1 to=%b decoded=%h success=%b lat=%0d, want 200/0/%0d", to, decoded_s[1], success_s[1], lat, 2 * (M + 1));
    end
`ifdef LDPC_BF_ITER_COUNT_EN
    checks++;
    if (iter_s[1] !== 8'd1) begin
      errors++;
      $display("FAIL budget1_iter got %0d want 1", iter_s[1]);
    end
`endif
    release_out(1);
    // Budget of zero: pure syndrome check.
    do_decode(2, 11'h0C0, lat, to);
    checks++;
    if (to || decoded_s[2] !== 11'h0C0 || success_s[2] !== 1'b0 || lat != M + 1) begin
      errors++;
      $display("FAIL budget0_bad to=%b decoded=%h success=%b lat=%0d, want 0C0/0/%0d", to, decoded_s[2], success_s[2], lat, M + 1);
    end
    release_out(2);
    do_decode(2, 11'h0C1, lat, to);
    checks++;
    if (to || decoded_s[2] !== 11'h0C1 || success_s[2] !== 1'b1) begin
      errors++;
      $display("FAIL budget0_good to=%b decoded=%h success=%b, want 0C1/1", to, decoded_s[2], success_s[2]);
    end
    release_out(2);
  endtask

  task automatic test_abort_and_hold();
    int lat;
    bit to;
    logic [10:0] held;
    do_decode(0, 11'h0C1, lat, to);
    release_out(0);
    // Start a decode, then reset in the third SYND cycle.
    code_in_s[0] = 11'h2C1;
    in_valid_s[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid_s[0] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (in_ready_s[0] !== 1'b1 || out_valid_s[0] !== 1'b0 || decoded_s[0] !== 11'h000 ||
        info_s[0] !== 6'h00 || success_s[0] !== 1'b0) begin
      errors++;
      $display("FAIL abort_reset in_ready=%b out_valid=%b decoded=%h info=%h success=%b, want 1/0/000/00/0",
               in_ready_s[0], out_valid_s[0], decoded_s[0], info_s[0], success_s[0]);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    // Result must stay put while the consumer stalls.
    do_decode(0, 11'h0C0, lat, to);
    held = decoded_s[0];
    checks++;
    if (to || held !== 11'h0C1) begin
      errors++;
      $display("FAIL hold_result to=%b decoded=%h want 0C1", to, held);
    end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (out_valid_s[0] !== 1'b1 || decoded_s[0] !== 11'h0C1 || success_s[0] !== 1'b1 || in_ready_s[0] !== 1'b0) begin
        errors++;
        $display("FAIL hold_stable cycle%0d out_valid=%b decoded=%h success=%b in_ready=%b, want 1/0C1/1/0",
                 c, out_valid_s[0], decoded_s[0], success_s[0], in_ready_s[0]);
      end
    end
    release_out(0);
    checks++;
    if (in_ready_s[0] !== 1'b1 || out_valid_s[0] !== 1'b0) begin
      errors++;
      $display("FAIL hold_release in_ready=%b out_valid=%b, want 1/0", in_ready_s[0], out_valid_s[0]);
    end
  endtask

  task automatic test_back_to_back();
    logic [10:0] w;
    logic [10:0] edec;
    bit eok;
    int eits;
    int lat;
    bit to;
    int sel;
    for (int i = 0; i < 60; i++) begin
      sel = i % 3;
      if (i % 2 == 0) begin
        w = 11'($urandom_range(0, 2047));
      end else begin
        w = ((i % 4 == 1) ? 11'h0C1 : 11'h000) ^ (11'd1 << $urandom_range(0, 10));
      end
      model_decode(w, mx[sel], edec, eok, eits);
      do_decode(sel, w, lat, to);
      checks++;
      if (to) begin
        errors++;
        $display("FAIL b2b_timeout inst%0d word=%h", sel, w);
        continue;
      end
      checks++;
      if (decoded_s[sel] !== edec || info_s[sel] !== edec[5:0] || success_s[sel] !== eok) begin
        errors++;
        $display("FAIL b2b_result inst%0d word=%h: got %h/%h/%b want %h/%h/%b",
                 sel, w, decoded_s[sel], info_s[sel], success_s[sel], edec, edec[5:0], eok);
      end
      checks++;
      if (lat != (eits + 1) * (M + 1)) begin
        errors++;
        $display("FAIL b2b_latency inst%0d word=%h: got %0d edges want %0d", sel, w, lat, (eits + 1) * (M + 1));
      end
`ifdef LDPC_BF_ITER_COUNT_EN
      checks++;
      if (iter_s[sel] !== 8'(eits)) begin
        errors++;
        $display("FAIL b2b_iter inst%0d word=%h: got %0d want %0d", sel, w, iter_s[sel], eits);
      end
`endif
      release_out(sel);
      checks++;
      if (in_ready_s[sel] !== 1'b1) begin
        errors++;
        $display("FAIL b2b_ready inst%0d: in_ready=%b want 1 right after transfer", sel, in_ready_s[sel]);
      end
    end
  endtask

  initial begin
    for (int s = 0; s < 3; s++) code_in_s[s] = '0;
    test_reset();
    test_directed();
    test_max_iter();
    test_abort_and_hold();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
